// File: rtl/conv2_maxpool_relu.sv
// conv2 output stage: 2x2 stride-2 max-pooling followed by ReLU on three lockstep channels.
// A half-width line buffer per channel carries even-row pair maxima into the odd row.
module conv2_maxpool_relu #(
   parameter int unsigned CONV_WIDTH  = 8,
   parameter int unsigned CONV_HEIGHT = 8,
   parameter int unsigned DATA_BITS   = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [DATA_BITS-1:0] conv_in_1,
   input  logic [DATA_BITS-1:0] conv_in_2,
   input  logic [DATA_BITS-1:0] conv_in_3,
   output logic [DATA_BITS-1:0] max_value_1,
   output logic [DATA_BITS-1:0] max_value_2,
   output logic [DATA_BITS-1:0] max_value_3,
   output logic                 valid_out_relu
);

   localparam int unsigned NUM_CH = 3;
   localparam int unsigned COL_W  = $clog2(CONV_WIDTH);
   localparam int unsigned ROW_W  = $clog2(CONV_HEIGHT);
   localparam int unsigned HALF_W = CONV_WIDTH / 2;
   localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             col_last;
   logic             row_last;
   logic             odd_col;
   logic             odd_row;
   logic [IDX_W-1:0] lbuf_idx;

   logic signed [DATA_BITS-1:0] px       [NUM_CH];
   logic signed [DATA_BITS-1:0] hold     [NUM_CH];
   logic signed [DATA_BITS-1:0] lbuf     [NUM_CH][HALF_W];
   logic signed [DATA_BITS-1:0] pair_max [NUM_CH];
   logic signed [DATA_BITS-1:0] quad_max [NUM_CH];
   logic signed [DATA_BITS-1:0] result   [NUM_CH];

   assign col_last = (col_cnt == COL_W'(CONV_WIDTH - 1));
   assign row_last = (row_cnt == ROW_W'(CONV_HEIGHT - 1));
   // Width and height are even, so parity is just the counter LSB.
   assign odd_col  = col_cnt[0];
   assign odd_row  = row_cnt[0];
   assign lbuf_idx = IDX_W'(col_cnt >> 1);

   assign px[0] = $signed(conv_in_1);
   assign px[1] = $signed(conv_in_2);
   assign px[2] = $signed(conv_in_3);

   // Signed maxima: horizontal pair, then pair against the buffered even-row pair.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pair_max[i] = (px[i] > hold[i]) ? px[i] : hold[i];
         quad_max[i] = (lbuf[i][lbuf_idx] > pair_max[i]) ? lbuf[i][lbuf_idx] : pair_max[i];
      end
   end

   // Raster position; frozen while valid_in is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (valid_in) begin
         if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
         end else begin
            col_cnt <= col_cnt + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hold[i]   <= '0;
            result[i] <= '0;
         end
         valid_out_relu <= 1'b0;
      end else begin
         valid_out_relu <= 1'b0;
         if (valid_in) begin
            if (!odd_col) begin
               for (int i = 0; i < NUM_CH; i++) hold[i] <= px[i];
            end else if (odd_row) begin
               for (int i = 0; i < NUM_CH; i++)
                  result[i] <= quad_max[i][DATA_BITS-1] ? '0 : quad_max[i];
               valid_out_relu <= 1'b1;
            end
         end
      end
   end

   // Line buffer contents are don't-care after reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (!rst && valid_in && odd_col && !odd_row) begin
         for (int i = 0; i < NUM_CH; i++) lbuf[i][lbuf_idx] <= pair_max[i];
      end
   end

   assign max_value_1 = result[0];
   assign max_value_2 = result[1];
   assign max_value_3 = result[2];

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Directed bench for conv2_maxpool_relu: ramp, negative, signed-corner, gapped,
// mid-frame reset and back-to-back frames, with hand-computed pooled results.
module tb_conv2_maxpool_relu;

   localparam int unsigned DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [DW-1:0] conv_in_1, conv_in_2, conv_in_3;
   logic [DW-1:0] max_value_1, max_value_2, max_value_3;
   logic          valid_out_relu;

   int errors = 0;
   int checks = 0;
   int spurious = 0;
   logic beat_at_edge = 1'b0;
   logic [DW-1:0] q1[$], q2[$], q3[$];

   // Pooled channel-1 ramp values for a frame of px=r*8+c.
   int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

   conv2_maxpool_relu #(.CONV_WIDTH(8), .CONV_HEIGHT(8), .DATA_BITS(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_in       (valid_in),
      .conv_in_1      (conv_in_1),
      .conv_in_2      (conv_in_2),
      .conv_in_3      (conv_in_3),
      .max_value_1    (max_value_1),
      .max_value_2    (max_value_2),
      .max_value_3    (max_value_3),
      .valid_out_relu (valid_out_relu)
   );

   always #5 clk = ~clk;

   always @(posedge clk) beat_at_edge <= valid_in & ~rst;

   always @(negedge clk) begin
      if (valid_out_relu === 1'b1) begin
         q1.push_back(max_value_1);
         q2.push_back(max_value_2);
         q3.push_back(max_value_3);
         if (!beat_at_edge) spurious++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_beat(input int a, input int b, input int c);
      @(negedge clk);
      valid_in  = 1'b1;
      conv_in_1 = DW'(a);
      conv_in_2 = DW'(b);
      conv_in_3 = DW'(c);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic clear_q();
      q1.delete();
      q2.delete();
      q3.delete();
   endtask

   // ch1 = ramp+off, ch2 = ramp+off+200, ch3 = 2047-ramp-off
   task automatic drive_frame(input int off, input bit gaps);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int v;
            if (gaps) idle($urandom_range(0, 2));
            v = r * 8 + c;
            drive_beat(v + off, v + off + 200, 2047 - v - off);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_in = 1'b1;
      conv_in_1 = 12'h7FF;
      conv_in_2 = 12'h7FF;
      conv_in_3 = 12'h7FF;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (valid_out_relu !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", valid_out_relu);
      end
      checks++;
      if (max_value_1 !== 12'h000 || max_value_2 !== 12'h000 || max_value_3 !== 12'h000) begin
         errors++;
         $display("FAIL reset_values: got %h %h %h want 000", max_value_1, max_value_2, max_value_3);
      end
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      idle(2);
      clear_q();
   endtask

   task automatic test_ramp();
      clear_q();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int v;
            v = r * 8 + c;
            drive_beat(v, v + 200, 2047 - v);
            if (v == 8) begin
               checks++;
               if (valid_out_relu !== 1'b0) begin
                  errors++;
                  $display("FAIL ramp_early_pulse: got %b want 0 after beat 8", valid_out_relu);
               end
            end
            if (v == 9) begin
               checks++;
               if (valid_out_relu !== 1'b1 || max_value_1 !== 12'd9) begin
                  errors++;
                  $display("FAIL ramp_first_pulse: got v=%b val=%0d want v=1 val=9",
                           valid_out_relu, max_value_1);
               end
            end
         end
      end
      idle(3);
      checks++;
      if (q1.size() != 16) begin
         errors++;
         $display("FAIL ramp_count: got %0d want 16", q1.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (q1[i] !== DW'(ramp_exp[i]) || q2[i] !== DW'(ramp_exp[i] + 200) ||
                q3[i] !== DW'(2047 - (ramp_exp[i] - 9))) begin
               errors++;
               $display("FAIL ramp_val[%0d]: got %0d %0d %0d want %0d %0d %0d", i, q1[i], q2[i],
                        q3[i], ramp_exp[i], ramp_exp[i] + 200, 2047 - (ramp_exp[i] - 9));
            end
         end
      end
   endtask

   task automatic test_negative();
      clear_q();
      for (int k = 0; k < 64; k++) drive_beat(-5, -5, -5);
      idle(3);
      checks++;
      if (q1.size() != 16) begin
         errors++;
         $display("FAIL neg_count: got %0d want 16", q1.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (q1[i] !== 12'h000 || q2[i] !== 12'h000 || q3[i] !== 12'h000) begin
               errors++;
               $display("FAIL neg_val[%0d]: got %h %h %h want 000", i, q1[i], q2[i], q3[i]);
            end
         end
      end
   endtask

   task automatic test_signed();
      clear_q();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int v;
            v = 0;
            if (r == 0 && c == 0) v = 'h800;
            if (r == 0 && c == 1) v = 'h7FF;
            if (r == 1 && c == 0) v = 'hFFF;
            if (r == 1 && c == 1) v = 'h001;
            drive_beat(v, v, v);
         end
      end
      idle(3);
      checks++;
      if (q1.size() != 16) begin
         errors++;
         $display("FAIL signed_count: got %0d want 16", q1.size());
      end else begin
         checks++;
         if (q1[0] !== 12'h7FF || q2[0] !== 12'h7FF || q3[0] !== 12'h7FF) begin
            errors++;
            $display("FAIL signed_block0: got %h %h %h want 7ff", q1[0], q2[0], q3[0]);
         end
         checks++;
         if (q1[1] !== 12'h000) begin
            errors++;
            $display("FAIL signed_block1: got %h want 000", q1[1]);
         end
      end
   endtask

   task automatic test_gaps();
      clear_q();
      spurious = 0;
      drive_frame(0, 1'b1);
      idle(3);
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL gap_spurious: got %0d pulses in gap cycles want 0", spurious);
      end
      checks++;
      if (q1.size() != 16) begin
         errors++;
         $display("FAIL gap_count: got %0d want 16", q1.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (q1[i] !== DW'(ramp_exp[i]) || q2[i] !== DW'(ramp_exp[i] + 200) ||
                q3[i] !== DW'(2047 - (ramp_exp[i] - 9))) begin
               errors++;
               $display("FAIL gap_val[%0d]: got %0d %0d %0d want %0d %0d %0d", i, q1[i], q2[i],
                        q3[i], ramp_exp[i], ramp_exp[i] + 200, 2047 - (ramp_exp[i] - 9));
            end
         end
      end
   endtask

   task automatic test_midframe_reset();
      for (int k = 0; k < 20; k++) drive_beat(k + 500, k + 500, k + 500);
      @(negedge clk);
      rst = 1'b1;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid_out_relu !== 1'b0 || max_value_1 !== 12'h000) begin
         errors++;
         $display("FAIL midreset_state: got v=%b val=%h want v=0 val=000", valid_out_relu, max_value_1);
      end
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      clear_q();
      drive_frame(0, 1'b0);
      idle(3);
      checks++;
      if (q1.size() != 16) begin
         errors++;
         $display("FAIL midreset_count: got %0d want 16", q1.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (q1[i] !== DW'(ramp_exp[i]) || q3[i] !== DW'(2047 - (ramp_exp[i] - 9))) begin
               errors++;
               $display("FAIL midreset_val[%0d]: got %0d %0d want %0d %0d", i, q1[i], q3[i],
                        ramp_exp[i], 2047 - (ramp_exp[i] - 9));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      drive_frame(0, 1'b0);
      drive_frame(100, 1'b0);
      idle(3);
      checks++;
      if (q1.size() != 32) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 32", q1.size());
      end else begin
         for (int i = 0; i < 32; i++) begin
            int off;
            int e;
            off = (i < 16) ? 0 : 100;
            e = ramp_exp[i % 16];
            checks++;
            if (q1[i] !== DW'(e + off) || q2[i] !== DW'(e + off + 200) ||
                q3[i] !== DW'(2047 - off - (e - 9))) begin
               errors++;
               $display("FAIL b2b_val[%0d]: got %0d %0d %0d want %0d %0d %0d", i, q1[i], q2[i],
                        q3[i], e + off, e + off + 200, 2047 - off - (e - 9));
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      valid_in = 1'b0;
      conv_in_1 = '0;
      conv_in_2 = '0;
      conv_in_3 = '0;
      test_reset();
      test_ramp();
      test_negative();
      test_signed();
      test_gaps();
      test_midframe_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
